// File: rtl/tl_pkg.sv
// Shared types for the traffic-light controller: phase codes, lamp encodings
// and approach directions.
package tl_pkg;

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    NS_R  = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    EW_R  = 3'd5,
    EMG_G = 3'd6
  } phase_e;

  typedef logic [2:0] lamp_t;

  localparam lamp_t LAMP_G = 3'b100;
  localparam lamp_t LAMP_Y = 3'b010;
  localparam lamp_t LAMP_R = 3'b001;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

endpackage

// File: rtl/tl_phase_ctrl.sv
// Phase sequencer for a 4-way intersection: NS/EW ring with yellow and all-red
// clearance, latched pedestrian service and emergency preemption.
module tl_phase_ctrl
  import tl_pkg::*;
#(
  parameter logic [63:0] G_CYC   = 64'd1000,
  parameter logic [63:0] Y_CYC   = 64'd200,
  parameter logic [63:0] R_CYC   = 64'd50,
  parameter logic [63:0] PED_CYC = 64'd1500
) (
  input  logic        clk,
  input  logic        rst,
  output logic        timer_load,
  output logic [63:0] timer_cycles,
  input  logic        timer_expired,
  input  logic        ped_req_ns,
  input  logic        ped_req_ew,
  input  logic        emerg_req,
  input  logic        emerg_dir,
  output logic [2:0]  ns_lamp,
  output logic [2:0]  ew_lamp,
  output logic        ped_walk_ns,
  output logic        ped_walk_ew,
  output logic [2:0]  phase
);

  phase_e phase_q, phase_d;
  dir_e   dir_q, dir_d;
  logic   entry_q, entry_d;
  logic   ped_ns_q, ped_ns_d, ped_ew_q, ped_ew_d;
  logic   walk_ns_q, walk_ns_d, walk_ew_q, walk_ew_d;
  lamp_t  ns_lamp_q, ns_lamp_d, ew_lamp_q, ew_lamp_d;
  logic   adv;

  always_comb begin
    // The timer still shows the previous phase's count during the load cycle.
    adv     = timer_expired && !entry_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    case (phase_q)
      NS_G: begin
        if (emerg_req) begin
          if (dir_e'(emerg_dir) == DIR_NS) begin
            phase_d = EMG_G;
            dir_d   = DIR_NS;
          end else begin
            phase_d = NS_Y;
          end
        end else if (adv) begin
          phase_d = NS_Y;
        end
      end
      NS_Y: if (adv) phase_d = NS_R;
      NS_R: begin
        if (adv) begin
          if (emerg_req) begin
            phase_d = EMG_G;
            dir_d   = dir_e'(emerg_dir);
          end else begin
            phase_d = EW_G;
          end
        end
      end
      EW_G: begin
        if (emerg_req) begin
          if (dir_e'(emerg_dir) == DIR_EW) begin
            phase_d = EMG_G;
            dir_d   = DIR_EW;
          end else begin
            phase_d = EW_Y;
          end
        end else if (adv) begin
          phase_d = EW_Y;
        end
      end
      EW_Y: if (adv) phase_d = EW_R;
      EW_R: begin
        if (adv) begin
          if (emerg_req) begin
            phase_d = EMG_G;
            dir_d   = dir_e'(emerg_dir);
          end else begin
            phase_d = NS_G;
          end
        end
      end
      EMG_G: if (!emerg_req) phase_d = (dir_q == DIR_NS) ? NS_Y : EW_Y;
      default: phase_d = EW_R;
    endcase

    entry_d  = (phase_d != phase_q) && (phase_d != EMG_G);
    // A request arriving in the clearing cycle survives for the next service.
    ped_ns_d = ped_req_ns | (ped_ns_q & ~(entry_q && phase_q == NS_G));
    ped_ew_d = ped_req_ew | (ped_ew_q & ~(entry_q && phase_q == EW_G));
    walk_ns_d = (phase_d == NS_G) && ((phase_q == NS_G) ? walk_ns_q : ped_ns_d);
    walk_ew_d = (phase_d == EW_G) && ((phase_q == EW_G) ? walk_ew_q : ped_ew_d);

    ns_lamp_d = LAMP_R;
    ew_lamp_d = LAMP_R;
    case (phase_d)
      NS_G:  ns_lamp_d = LAMP_G;
      NS_Y:  ns_lamp_d = LAMP_Y;
      EW_G:  ew_lamp_d = LAMP_G;
      EW_Y:  ew_lamp_d = LAMP_Y;
      EMG_G: begin
        if (dir_d == DIR_NS) ns_lamp_d = LAMP_G;
        else                 ew_lamp_d = LAMP_G;
      end
      default: ;
    endcase
  end

  always_comb begin
    timer_cycles = 64'd0;
    case (phase_q)
      NS_G:        timer_cycles = walk_ns_q ? PED_CYC : G_CYC;
      EW_G:        timer_cycles = walk_ew_q ? PED_CYC : G_CYC;
      NS_Y, EW_Y:  timer_cycles = Y_CYC;
      NS_R, EW_R:  timer_cycles = R_CYC;
      default:     timer_cycles = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= EW_R;
      dir_q     <= DIR_NS;
      entry_q   <= 1'b1;
      ped_ns_q  <= 1'b0;
      ped_ew_q  <= 1'b0;
      walk_ns_q <= 1'b0;
      walk_ew_q <= 1'b0;
      ns_lamp_q <= LAMP_R;
      ew_lamp_q <= LAMP_R;
    end else begin
      phase_q   <= phase_d;
      dir_q     <= dir_d;
      entry_q   <= entry_d;
      ped_ns_q  <= ped_ns_d;
      ped_ew_q  <= ped_ew_d;
      walk_ns_q <= walk_ns_d;
      walk_ew_q <= walk_ew_d;
      ns_lamp_q <= ns_lamp_d;
      ew_lamp_q <= ew_lamp_d;
    end
  end

  assign timer_load  = entry_q;
  assign ns_lamp     = ns_lamp_q;
  assign ew_lamp     = ew_lamp_q;
  assign ped_walk_ns = walk_ns_q;
  assign ped_walk_ew = walk_ew_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_tl_phase_ctrl.sv
// Bench for tl_phase_ctrl with a countdown timer stand-in and a dwell-based
// reference model of the phase ring.
module tb_tl_phase_ctrl;
  import tl_pkg::*;

  localparam logic [63:0] GC = 64'd10;
  localparam logic [63:0] YC = 64'd3;
  localparam logic [63:0] RC = 64'd1;
  localparam logic [63:0] PC = 64'd20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timer_load;
  logic [63:0] timer_cycles;
  logic        timer_expired;
  logic        ped_req_ns = 1'b0;
  logic        ped_req_ew = 1'b0;
  logic        emerg_req = 1'b0;
  logic        emerg_dir = 1'b0;
  logic [2:0]  ns_lamp, ew_lamp, phase;
  logic        ped_walk_ns, ped_walk_ew;

  int n_checks = 0;
  int n_errors = 0;

  tl_phase_ctrl #(.G_CYC(GC), .Y_CYC(YC), .R_CYC(RC), .PED_CYC(PC)) dut (
    .clk(clk), .rst(rst), .timer_load(timer_load), .timer_cycles(timer_cycles),
    .timer_expired(timer_expired), .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .emerg_req(emerg_req), .emerg_dir(emerg_dir), .ns_lamp(ns_lamp), .ew_lamp(ew_lamp),
    .ped_walk_ns(ped_walk_ns), .ped_walk_ew(ped_walk_ew), .phase(phase)
  );

  always #5 clk = ~clk;

  // tl_timer stand-in: load takes the count, then count down to zero and hold.
  logic [63:0] tmr_q = 64'd0;
  always @(posedge clk) begin
    if (rst)             tmr_q <= 64'd0;
    else if (timer_load) tmr_q <= timer_cycles;
    else if (tmr_q != 0) tmr_q <= tmr_q - 64'd1;
  end
  assign timer_expired = (tmr_q == 64'd0);

  // Reference model: each timed phase lasts count+2 clocks, tracked directly.
  phase_e m_ph = EW_R;
  int     m_left = 0;
  bit     m_load = 1'b1, m_pn = 1'b0, m_pe = 1'b0, m_wn = 1'b0, m_we = 1'b0, m_dir = 1'b0;

  function automatic logic [63:0] dwell_cnt(phase_e p, bit wn, bit we);
    case (p)
      NS_G:       return wn ? PC : GC;
      EW_G:       return we ? PC : GC;
      NS_Y, EW_Y: return YC;
      NS_R, EW_R: return RC;
      default:    return 64'd0;
    endcase
  endfunction

  function automatic lamp_t exp_lamp(phase_e p, bit dir, bit ns_side);
    case (p)
      NS_G:    return ns_side ? LAMP_G : LAMP_R;
      NS_Y:    return ns_side ? LAMP_Y : LAMP_R;
      EW_G:    return ns_side ? LAMP_R : LAMP_G;
      EW_Y:    return ns_side ? LAMP_R : LAMP_Y;
      EMG_G:   return ((dir == 1'b0) == ns_side) ? LAMP_G : LAMP_R;
      default: return LAMP_R;
    endcase
  endfunction

  always @(posedge clk) begin : model
    phase_e nph;
    bit     last, npn, npe;
    if (rst) begin
      m_ph = EW_R; m_left = int'(RC) + 2; m_load = 1'b1;
      m_pn = 1'b0; m_pe = 1'b0; m_wn = 1'b0; m_we = 1'b0; m_dir = 1'b0;
    end else begin
      nph  = m_ph;
      last = (m_left == 1);
      case (m_ph)
        NS_G: if (emerg_req) begin
                if (!emerg_dir) begin nph = EMG_G; m_dir = 1'b0; end else nph = NS_Y;
              end else if (last) nph = NS_Y;
        NS_Y: if (last) nph = NS_R;
        NS_R: if (last) begin
                if (emerg_req) begin nph = EMG_G; m_dir = emerg_dir; end else nph = EW_G;
              end
        EW_G: if (emerg_req) begin
                if (emerg_dir) begin nph = EMG_G; m_dir = 1'b1; end else nph = EW_Y;
              end else if (last) nph = EW_Y;
        EW_Y: if (last) nph = EW_R;
        EW_R: if (last) begin
                if (emerg_req) begin nph = EMG_G; m_dir = emerg_dir; end else nph = NS_G;
              end
        default: if (!emerg_req) nph = m_dir ? EW_Y : NS_Y;
      endcase
      npn = ped_req_ns || (m_pn && !(m_load && m_ph == NS_G));
      npe = ped_req_ew || (m_pe && !(m_load && m_ph == EW_G));
      if (nph != m_ph) begin
        m_wn = (nph == NS_G) && npn;
        m_we = (nph == EW_G) && npe;
        if (nph == EMG_G) begin m_load = 1'b0; m_left = 0; end
        else begin m_load = 1'b1; m_left = int'(dwell_cnt(nph, m_wn, m_we)) + 2; end
      end else begin
        m_load = 1'b0;
        if (m_left > 0) m_left = m_left - 1;
      end
      m_ph = nph; m_pn = npn; m_pe = npe;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("phase",   64'(phase), 64'(m_ph));
    chk("ns_lamp", 64'(ns_lamp), 64'(exp_lamp(m_ph, m_dir, 1'b1)));
    chk("ew_lamp", 64'(ew_lamp), 64'(exp_lamp(m_ph, m_dir, 1'b0)));
    chk("walk_ns", 64'(ped_walk_ns), 64'(m_wn));
    chk("walk_ew", 64'(ped_walk_ew), 64'(m_we));
    chk("load",    64'(timer_load), 64'(m_load));
    chk("cycles",  timer_cycles, dwell_cnt(m_ph, m_wn, m_we));
    chk("safety",  64'(ns_lamp != LAMP_R && ew_lamp != LAMP_R), 64'd0);
  endtask

  task automatic measure(input string tag, input phase_e p, input int len);
    int n = 0;
    while (phase == p && n < 200) begin n++; tick(); end
    chk(tag, 64'(n), 64'(len));
  endtask

  task automatic wait_ph(input phase_e p);
    int n = 0;
    while (phase != p && n < 300) begin n++; tick(); end
    chk("wait_phase", 64'(phase), 64'(p));
  endtask

  initial begin
    // Reset release and the plain ring
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_phase", 64'(phase), 64'(EW_R));
    chk("rst_ns", 64'(ns_lamp), 64'(LAMP_R));
    chk("rst_ew", 64'(ew_lamp), 64'(LAMP_R));
    chk("rst_walk", 64'({ped_walk_ns, ped_walk_ew}), 64'd0);
    chk("rst_load", 64'(timer_load), 64'd1);
    measure("d_ew_r0", EW_R, 3);
    measure("d_ns_g0", NS_G, 12);
    measure("d_ns_y0", NS_Y, 5);
    measure("d_ns_r0", NS_R, 3);
    measure("d_ew_g0", EW_G, 12);

    // Pedestrian pulse during EW green extends the next NS green
    wait_ph(EW_G);
    repeat (2) tick();
    ped_req_ns = 1'b1; tick(); ped_req_ns = 1'b0;
    wait_ph(NS_G);
    chk("walk_on", 64'(ped_walk_ns), 64'd1);
    measure("d_ns_g_ped", NS_G, 22);
    wait_ph(NS_G);
    chk("walk_off", 64'(ped_walk_ns), 64'd0);
    measure("d_ns_g_plain", NS_G, 12);

    // Request landing in the NS green entry cycle is kept for the next one
    wait_ph(NS_G);
    ped_req_ns = 1'b1; tick(); ped_req_ns = 1'b0;
    measure("d_ns_g_cur", NS_G, 11);
    wait_ph(NS_G);
    measure("d_ns_g_next", NS_G, 22);

    // Preemption toward EW from NS green
    wait_ph(NS_G);
    repeat (3) tick();
    emerg_req = 1'b1; emerg_dir = 1'b1;
    tick();
    chk("pre_ns_y", 64'(phase), 64'(NS_Y));
    measure("d_pre_ns_y", NS_Y, 5);
    measure("d_pre_ns_r", NS_R, 3);
    chk("emg_phase", 64'(phase), 64'(EMG_G));
    chk("emg_ew_g", 64'(ew_lamp), 64'(LAMP_G));
    repeat (4) tick();
    emerg_dir = 1'b0;
    repeat (4) tick();
    chk("emg_dir_hold", 64'(ew_lamp), 64'(LAMP_G));
    emerg_req = 1'b0;
    tick();
    chk("emg_exit", 64'(phase), 64'(EW_Y));
    measure("d_post_ew_y", EW_Y, 5);
    measure("d_post_ew_r", EW_R, 3);
    chk("emg_resume", 64'(phase), 64'(NS_G));

    // Preemption in the matching green: no lamp change, no load
    repeat (2) tick();
    emerg_req = 1'b1; emerg_dir = 1'b0;
    tick();
    chk("same_emg", 64'(phase), 64'(EMG_G));
    chk("same_ns_g", 64'(ns_lamp), 64'(LAMP_G));
    chk("same_noload", 64'(timer_load), 64'd0);
    repeat (3) tick();
    emerg_req = 1'b0;
    tick();
    chk("same_exit", 64'(phase), 64'(NS_Y));

    // Reset in the middle of EW yellow, with an NS request pending
    wait_ph(EW_Y);
    tick();
    ped_req_ns = 1'b1; tick(); ped_req_ns = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mrst_phase", 64'(phase), 64'(EW_R));
    chk("mrst_lamps", 64'({ns_lamp, ew_lamp}), 64'({LAMP_R, LAMP_R}));
    chk("mrst_walk", 64'({ped_walk_ns, ped_walk_ew}), 64'd0);
    measure("d_mrst_ew_r", EW_R, 3);
    chk("mrst_latch", 64'(ped_walk_ns), 64'd0);
    measure("d_mrst_ns_g", NS_G, 12);

    // Random traffic against the model
    repeat (3000) begin
      rst        = ($urandom_range(0, 999) == 0);
      ped_req_ns = ($urandom_range(0, 29) == 0);
      ped_req_ew = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 79) == 0) emerg_req = ~emerg_req;
      if ($urandom_range(0, 9) == 0)  emerg_dir = 1'($urandom_range(0, 1));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_phase_ctrl.md
Name: tl_phase_ctrl

Overview:
- 4-direction phase sequencer for the intersection. It alternates right-of-way between the NS and EW approach pairs through green, yellow and all-red phases, and serves latched pedestrian requests and emergency preemption.
- It is the stage directly upstream of tl_timer. It drives tl_timer's load/cycles inputs and consumes its expired output.
- Lamp and walk outputs go to the output driver stage.

Parameters:
- G_CYC, 64'd1000, base green dwell count.
- Y_CYC, 64'd200, yellow dwell count.
- R_CYC, 64'd50, all-red clearance dwell count.
- PED_CYC, 64'd1500, green dwell count used when a pedestrian request is pending for that direction.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- timer_load  out  1  one-cycle pulse to tl_timer load, issued on phase entry.
- timer_cycles  out  64  count for tl_timer cycles, decoded from the current phase.
- timer_expired  in  1  from tl_timer expired.
- ped_req_ns  in  1  pedestrian button, NS crossing; single-cycle pulse or level.
- ped_req_ew  in  1  pedestrian button, EW crossing.
- emerg_req  in  1  emergency preemption request; level, held for its duration.
- emerg_dir  in  1  requested preemption direction: 0 = NS, 1 = EW.
- ns_lamp  out  3  one-hot {G,Y,R} for the NS approaches.
- ew_lamp  out  3  one-hot {G,Y,R} for the EW approaches.
- ped_walk_ns  out  1  walk indication, NS crossing.
- ped_walk_ew  out  1  walk indication, EW crossing.
- phase  out  3  current phase_e code, for debug and monitoring.

Behaviour:
- Reset is a single clock with a synchronous active-high reset. While rst=1:
  - phase=EW_R; entry_q=1; ped latches=0; emerg_dir_q=0.
  - ns_lamp=ew_lamp=R; walk outputs=0; timer_load=entry_q=1 (harmless while the timer is held in reset).
- After rst deasserts, the first cycle is an EW_R entry, so the first green is NS_G.
- Phases: NS_G, NS_Y, NS_R, EW_G, EW_Y, EW_R, EMG_G.
- Normal ring: NS_G->NS_Y->NS_R->EW_G->EW_Y->EW_R->NS_G.
- Phase entry rules:
  - entry_q is set on every state change and cleared one cycle later.
  - timer_load = entry_q.
  - timer_cycles is decoded combinationally from the current phase.
- Advance condition: timer_expired && !timer_load. Expired is ignored in the load cycle because the timer still shows the stale count.
- Dwell: each timed phase occupies exactly cycles+2 clocks (load cycle, cycles countdown, expired cycle).
- cycles=0 gives a 2-clock dwell.
- Green count selection, fixed at entry from the latch for that direction:
  - PED_CYC if that direction's ped latch is set.
  - Otherwise G_CYC.
  - Y phases use Y_CYC; R phases use R_CYC.
- Pedestrian latches:
  - A latch sets on its request input at any time.
  - It clears in the entry cycle of that direction's green.
  - If set and clear coincide, set wins (the request is re-served next cycle of that direction).
  - ped_walk_x=1 during x_G only if the latch was set at entry; registered flag.
  - Walk is 0 in all other phases, including EMG_G.
- Lamps:
  - x_G: x=G, other=R.
  - x_Y: x=Y, other=R.
  - NS_R and EW_R: both R.
  - EMG_G: dir_q side=G, other=R.
- Emergency preemption:
  - In the green of the direction equal to emerg_dir: go to EMG_G next cycle. No lamp change and no timer load is required.
  - In the green of the opposite direction: force an immediate transition to that direction's Y; the Y dwells normally.
  - In Y or R: finish the dwell normally.
  - On R expiry with emerg_req=1: go to EMG_G with emerg_dir latched into emerg_dir_q.
  - EMG_G is untimed, so timer_load is not asserted.
  - emerg_dir changes while in EMG_G are ignored.
  - emerg_req=0 in EMG_G: go to dir_q's Y, then resume the normal ring.
- No green phase on both axes ever; NS and EW never show non-R simultaneously (safety invariant).

Decomposition:
- Shared package tl_pkg holds:
  - phase_e enum, 3-bit, codes NS_G=0..EW_R=5, EMG_G=6.
  - lamp_t with LAMP_G=3'b100, LAMP_Y=3'b010, LAMP_R=3'b001.
  - dir_e with DIR_NS=0, DIR_EW=1.
- Single-module implementation.
- tl_timer is instantiated alongside in the parent and in the bench, not inside this block.

Test Plan (G=10, Y=3, R=1, PED=20; bench includes tl_timer):
- Reset release, no requests -> EW_R for 3 clocks, then NS_G 12, NS_Y 5, NS_R 3, EW_G 12. Both lamps R during R phases.
- ped_req_ns pulse during EW_G -> next NS_G dwells 22 clocks with ped_walk_ns=1 throughout; the following NS_G reverts to 12 clocks with walk 0.
- ped_req_ns pulsed exactly in the NS_G entry cycle -> the latch stays set and the next NS_G is 22 clocks.
- emerg_req=1, emerg_dir=EW in cycle 4 of NS_G -> NS_Y next cycle (5 clocks), NS_R (3), then EMG_G with ew_lamp=G. emerg_dir flipped mid-EMG is ignored. Dropping emerg_req -> EW_Y 5 clocks, then EW_R, then NS_G.
- emerg_req=1, emerg_dir=NS during NS_G -> EMG_G next cycle with ns_lamp staying G and no timer_load.
- rst asserted mid-EW_Y -> next cycle phase=EW_R, both lamps R, walk 0, latches clear. The sequence restarts as in the first scenario.
- Throughout all scenarios, an assertion checks the safety invariant: never both lamps non-R.
